// File: rtl/tx_pkg.sv
// Shared types and helpers for the multi-buffer TX serializer.
// Imported by the word queue and the serializer top.
package tx_pkg;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_t;

  // Pointer width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tx_word_queue.sv
// Circular word queue with count, flush and push/pop.
// Flush drops a same-cycle push and realigns rd_ptr to wr_ptr.
module tx_word_queue
  import tx_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_BUF = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            head,
  input  logic                         flush,
  output logic [$clog2(NUM_BUF+1)-1:0] count
);

  localparam int PW = clog2_min1(NUM_BUF);
  localparam int CW = $clog2(NUM_BUF + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_BUF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_BUF);

  logic [DATA_W-1:0] mem [NUM_BUF];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign push_ready = (count < CNT_FULL);
  assign push       = push_valid && push_ready && !flush;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BUF; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/tx_multibuf_serializer.sv
// TX serializer: queued words shifted out one bit per bit_step.
// Back-to-back frames hand off in the same edge with no idle gap.
module tx_multibuf_serializer
  import tx_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_BUF   = 2,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_LVL  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [DATA_W-1:0]            load_data,
  input  logic                         start_tx,
  input  logic                         bit_step,
  input  logic                         flush,
  output logic                         tx_out,
  output logic                         tx_active,
  output logic                         frame_done,
  output logic                         underrun,
  output logic [$clog2(NUM_BUF+1)-1:0] fill_level
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  tx_state_t         state;
  tx_state_t         state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] head;
  logic [BW-1:0]     bit_cnt;
  logic              pop;
  logic              shift;
  logic              done_nxt;
  logic              urun_set;
  logic              have_word;
  logic              last;

  tx_word_queue #(
    .DATA_W  (DATA_W),
    .NUM_BUF (NUM_BUF)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (load_valid),
    .push_ready (load_ready),
    .push_data  (load_data),
    .pop        (pop),
    .head       (head),
    .flush      (flush),
    .count      (fill_level)
  );

  assign have_word = (fill_level != '0);
  assign last      = (bit_cnt == BIT_LAST);
  assign tx_active = (state == TX_SHIFT);
  assign tx_out    = !tx_active ? IDLE_LVL
                   : MSB_FIRST  ? shreg[DATA_W-1]
                   :              shreg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TX_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    shift     = 1'b0;
    done_nxt  = 1'b0;
    urun_set  = 1'b0;
    unique case (1'b1)
      (state == TX_IDLE): begin
        if (start_tx && have_word) begin
          pop       = 1'b1;
          state_nxt = TX_SHIFT;
        end
      end
      (state == TX_SHIFT): begin
        if (bit_step) begin
          shift = 1'b1;
          if (last) begin
            done_nxt = 1'b1;
            if (start_tx && have_word) begin
              pop = 1'b1;
            end else begin
              state_nxt = TX_IDLE;
              urun_set  = start_tx;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (pop) begin
      shreg   <= head;
      bit_cnt <= '0;
    end else if (shift) begin
      shreg   <= MSB_FIRST ? {shreg[DATA_W-2:0], 1'b0}
                           : {1'b0, shreg[DATA_W-1:1]};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // A same-cycle underrun wins over flush: the queue is empty either way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= done_nxt;
      if (urun_set) begin
        underrun <= 1'b1;
      end else if (flush) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/tx_multibuf_serializer.md
Name: tx_multibuf_serializer

Overview:
- Parametrised successor to the two-buffer TX datapath.
- Replaces the fixed pair of load/shift-controlled 32-bit buffers with a NUM_BUF-deep circular word queue, a valid/ready load handshake, a dedicated shift register and automatic back-to-back buffer hand-off.
- Sits between the bus-side register interface and the I2C bit-level controller.
- The controller paces each bit through bit_step.

Parameters:
- DATA_W, 32, word width in bits (>=2).
- NUM_BUF, 2, queue depth in words (>=1).
- MSB_FIRST, 1, 1 = serialise MSB first, 0 = LSB first.
- IDLE_LVL, 1, value driven on tx_out when no frame is active (I2C line idle high).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- load_valid  input  1  producer offers load_data
- load_ready  output  1  queue can accept a word
- load_data  input  DATA_W  word to enqueue
- start_tx  input  1  level enable; while high, queued words are transmitted
- bit_step  input  1  one-cycle strobe from bit controller: advance to next bit
- flush  input  1  discard queued (not active) words; clear underrun
- tx_out  output  1  current serial bit
- tx_active  output  1  a frame is being shifted
- frame_done  output  1  one-cycle pulse when last bit of a frame is consumed
- underrun  output  1  sticky: frame ended with start_tx high and queue empty
- fill_level  output  $clog2(NUM_BUF+1)  words currently queued

Behaviour:
Reset (async, rst_n=0): all outputs take their reset values immediately.
- tx_out=IDLE_LVL, tx_active=0, frame_done=0, underrun=0, fill_level=0, load_ready=1.
- Queue pointers, bit counter and FSM are cleared to IDLE.
- Reset mid-frame aborts the frame with no frame_done.

Queue:
- Circular buffer with wr_ptr and rd_ptr, each wrapping NUM_BUF-1 -> 0, plus a count register.
- load_ready = (count < NUM_BUF). No same-cycle bypass when full.
- Push occurs when load_valid && load_ready.
- Pop occurs on frame start. Push and pop in the same cycle leave count unchanged.
- flush sets count=0 and rd_ptr=wr_ptr, and clears underrun. A push in the same cycle as flush is dropped. flush has priority over push but does not affect the active frame.

FSM, states IDLE and SHIFT:
- IDLE:
  - tx_out=IDLE_LVL.
  - If start_tx && count>0: pop the head word into the shift register, bit_cnt=0, go to SHIFT.
  - Latency: the first bit appears on tx_out the cycle after start_tx is sampled with a non-empty queue.
- SHIFT:
  - tx_out = shreg[DATA_W-1] if MSB_FIRST, else shreg[0]. tx_active=1.
  - On bit_step, shift by one toward the output end and increment bit_cnt.
  - bit_step while in IDLE is ignored.
  - On bit_step with bit_cnt==DATA_W-1, pulse frame_done for exactly one cycle, then:
    - if start_tx && count>0: pop the next word in the same edge and stay in SHIFT. This is the seamless buffer swap: no idle cycle and no IDLE_LVL glitch.
    - else if start_tx && count==0: set underrun and go to IDLE.
    - else: go to IDLE.
- Deasserting start_tx mid-frame does not abort; the current frame completes and no further pop occurs.
- Counter widths: bit_cnt is $clog2(DATA_W) bits; pointers are $clog2(NUM_BUF) bits, minimum 1.
- NUM_BUF=1 is legal and behaves as a single holding buffer plus the shift register.

Decomposition:
- Shared package tx_pkg holds:
  - the state enum (TX_IDLE, TX_SHIFT);
  - a function clog2_min1.
- One sub-module is natural: tx_word_queue, the circular buffer with count, flush and push/pop.
- The serializer FSM and shift register stay in the top-level module.

Test Plan:
- DATA_W=32, NUM_BUF=2: push 32'd67, start_tx=1, bit_step every 4 cycles -> tx_out carries 0x00000043 MSB first (25 zeros, then 1,0,0,0,0,1,1), one frame_done, then tx_out=1 and tx_active=0.
- DATA_W=8, NUM_BUF=2: push 0xA5 and 0x3C, start_tx=1, bit_step every cycle -> 16 contiguous bits 10100101 00111100, frame_done at bits 8 and 16, tx_active never drops between frames.
- DATA_W=8, NUM_BUF=2: push 3 words with start_tx=0 -> third push stalls (load_ready=0, fill_level=2); raise start_tx -> load_ready returns the cycle after the first pop and the third word is accepted.
- DATA_W=8, MSB_FIRST=0: push 0x01, start_tx held high, queue otherwise empty -> tx_out=1 on the first bit then 0s; underrun=1 after frame_done; flush -> underrun=0.
- Pull rst_n low midway through bit 5 of 0xFF -> tx_out=1, tx_active=0, fill_level=0 asynchronously (before the next clk edge), no frame_done; after release, normal operation resumes.
- Push 0x11 and 0x22, start_tx=1, flush asserted during the first frame -> 0x11 completes, 0x22 is discarded, FSM returns to IDLE with underrun set (start_tx still high, queue empty).
